wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register. Takes the W-stage fields (ALU result, raw load doubleword, PC), formats load data, selects the writeback value, and commits it into a 32×64 integer register file. Serves the decode stage through two read ports with same-cycle write bypass. Keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 64, datapath width
- NREG, 32, architectural registers; x0 hardwired to zero

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- valid_W  in  1  W-stage holds a real instruction (not a bubble)
- wb_en_W  in  1  instruction writes rd
- rd_W  in  5  destination register index
- wb_sel_W  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- funct3_W  in  3  load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- alu_out_W  in  XLEN  ALU result; for loads, the effective address
- ld_data_W  in  XLEN  raw aligned doubleword from data memory
- current_pc_W  in  XLEN  PC of the W-stage instruction
- rs1_index  in  5  decode read port 1 index
- rs2_index  in  5  decode read port 2 index
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_data  out  XLEN  read port 2 data (combinational)
- wb_data_W  out  XLEN  selected writeback value (combinational, for forwarding)
- instret  out  64  retired-instruction count (registered)

## Operation
- Commit condition: we = valid_W & wb_en_W & (wb_sel_W != 11) & (rd_W != 0).
- Load formatting: off = alu_out_W[2:0]; sh = ld_data_W >> (8·off), zero-filling from the top. Then lb/lbu take sh[7:0], lh/lhu take sh[15:0], lw/lwu take sh[31:0], ld takes sh[63:0]. Signed forms sign-extend to 64 bits; unsigned forms zero-extend. funct3 111 yields 0.
- Misaligned accesses crossing the doubleword are not detected. Missing upper bytes read as zero, then extension applies.
- Writeback select: 00 → alu_out_W; 01 → formatted load; 10 → current_pc_W + 4 (mod 2^64); 11 → wb_data_W = 0, no write.
- Register file: on we, reg[rd_W] ← wb_data_W at the rising edge. x0 is never stored and always reads 0.
- Read ports return reg[index] combinationally, with one exception: if we is high and index == rd_W (index ≠ 0), the port returns wb_data_W instead (write-first bypass).
- instret increments by 1 on each rising edge with valid_W = 1, whether or not a register is written. It wraps from 2^64−1 to 0.
- No state machine. The only state is the register array and instret.

## Timing
- Reset (rst = 0, asynchronous): x1..x31 ← 0 and instret ← 0 immediately. Reads return 0 during reset.
- Register write latency: 1 edge. The value is readable through the bypass in the same cycle and from storage from the next cycle.
- wb_data_W, rs1_data and rs2_data are purely combinational from current inputs and state; there is no added latency.
- instret is visible one cycle after the retiring edge.
- Simultaneous read of the register being written: both ports may hit the same rd at once; both see the bypass value.
- Reset asserted mid-stream: any write at that edge is lost, and state stays 0 until the first edge after rst deasserts.
- Bubble (valid_W = 0): no write and no count, even if wb_en_W = 1.

## Test plan
- Reset: hold rst = 0 with valid_W = 1. Expect instret = 0 and rs1_data = rs2_data = 0 for all indices. Release rst and write x5 = 0x1234 (wb_sel 00). Next cycle rs1_index = 5 reads 0x1234, and instret = 1.
- Load formatting: ld_data_W = 0x8877_6655_4433_2211_F0 is too wide, so use 0x8877665544332211 instead.
  - lb at off 7 → 0xFFFFFFFFFFFFFF88
  - lbu at off 7 → 0x88
  - lh at off 6 → 0xFFFFFFFFFFFF8877
  - lw at off 4 → 0xFFFFFFFF88776655
  - lwu at off 4 → 0x88776655
  - ld at off 0 → whole word
  - lh at off 7 → 0x88, zero-filled then sign-extended → 0x0000000000000088
- Bypass: write x10 = 0xDEADBEEF with rs1_index = rs2_index = 10 in the same cycle. Both ports show 0xDEADBEEF in that cycle, and again afterwards from storage.
- x0 and suppression:
  - Write rd = 0 with 0xFFFF. x0 reads 0 and no bypass occurs.
  - wb_sel 11 → no write, wb_data_W = 0.
  - valid_W = 0 with wb_en_W = 1 → no write, instret unchanged.
- JAL link and wrap: wb_sel 10 with current_pc_W = 0xFFFFFFFFFFFFFFFC writes 0 to rd. Force instret near wrap by running 2^64 − 1 retires in model or via a backdoor preload; the next retire gives 0.
- Async reset mid-stream: assert rst between edges after 3 writes. Outputs go to 0 at once, without waiting for an edge.

Source files
------------

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Writeback stage with load formatting, 32x64 register file
//                (write-first bypass) and retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_W,
    input  logic            wb_en_W,
    input  logic [4:0]      rd_W,
    input  logic [1:0]      wb_sel_W,
    input  logic [2:0]      funct3_W,
    input  logic [XLEN-1:0] alu_out_W,
    input  logic [XLEN-1:0] ld_data_W,
    input  logic [XLEN-1:0] current_pc_W,
    input  logic [4:0]      rs1_index,
    input  logic [4:0]      rs2_index,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data_W,
    output logic [63:0]     instret
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC   = 2'b10;

    logic [XLEN-1:0] regs_q [NREG];
    logic [63:0]     instret_q;
    logic [63:0]     instret_d;
    logic            we;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_fmt;

    // Bytes shifted past the top of the doubleword come in as zero before extension.
    always_comb begin
        ld_fmt   = '0;
        ld_shift = ld_data_W >> {alu_out_W[2:0], 3'b000};
        case (funct3_W)
            3'b000:  ld_fmt = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
            3'b001:  ld_fmt = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_fmt = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
            3'b011:  ld_fmt = ld_shift;
            3'b100:  ld_fmt = {{(XLEN-8){1'b0}},  ld_shift[7:0]};
            3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            3'b110:  ld_fmt = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
            default: ld_fmt = '0;
        endcase
    end

    always_comb begin
        wb_data_W = '0;
        case (wb_sel_W)
            SEL_ALU:  wb_data_W = alu_out_W;
            SEL_LOAD: wb_data_W = ld_fmt;
            SEL_PC:   wb_data_W = current_pc_W + XLEN'(4);
            default:  wb_data_W = '0;
        endcase
    end

    // Gating with rst keeps the bypass from leaking data while reset is held.
    assign we = rst & valid_W & wb_en_W & (wb_sel_W != 2'b11) & (rd_W != 5'd0);

    assign rs1_data = (we && (rs1_index == rd_W)) ? wb_data_W : regs_q[rs1_index];
    assign rs2_data = (we && (rs2_index == rd_W)) ? wb_data_W : regs_q[rs2_index];

    assign instret_d = valid_W ? (instret_q + 64'd1) : instret_q;
    assign instret   = instret_q;

    // Entry 0 is reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            instret_q <= '0;
        end else begin
            if (we) begin
                regs_q[rd_W] <= wb_data_W;
            end
            instret_q <= instret_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_regfile
//  Description : Scoreboard bench for wb_regfile against a byte-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        valid_W;
    logic        wb_en_W;
    logic [4:0]  rd_W;
    logic [1:0]  wb_sel_W;
    logic [2:0]  funct3_W;
    logic [63:0] alu_out_W;
    logic [63:0] ld_data_W;
    logic [63:0] current_pc_W;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] wb_data_W;
    logic [63:0] instret;

    wb_regfile #(.XLEN(64), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_W      (valid_W),
        .wb_en_W      (wb_en_W),
        .rd_W         (rd_W),
        .wb_sel_W     (wb_sel_W),
        .funct3_W     (funct3_W),
        .alu_out_W    (alu_out_W),
        .ld_data_W    (ld_data_W),
        .current_pc_W (current_pc_W),
        .rs1_index    (rs1_index),
        .rs2_index    (rs2_index),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_data_W    (wb_data_W),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] wb;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;
    logic [63:0] m_regs [32];
    logic [63:0] m_cnt;

    function automatic logic [63:0] model_load(logic [63:0] ld, logic [2:0] off, logic [2:0] f3);
        logic [63:0] v;
        int          nbytes;
        v = '0;
        if (f3 == 3'b111) return 64'd0;
        nbytes = 1 << f3[1:0];
        for (int k = 0; k < nbytes; k++) begin
            int src;
            src = int'(off) + k;
            if (src < 8) v[8*k +: 8] = ld[8*src +: 8];
        end
        if (!f3[2] && v[8*nbytes-1]) begin
            for (int b = 8*nbytes; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [63:0] model_wb(logic [1:0] sel, logic [2:0] f3, logic [63:0] alu,
                                             logic [63:0] ld, logic [63:0] pc);
        case (sel)
            2'b00:   return alu;
            2'b01:   return model_load(ld, alu[2:0], f3);
            2'b10:   return pc + 64'd4;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(string name, string fld, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h, expected %h", name, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, "rs1", rs1_data, e.r1);
            chk(e.name, "rs2", rs2_data, e.r2);
            chk(e.name, "wb", wb_data_W, e.wb);
            chk(e.name, "instret", instret, e.cnt);
        end
    end

    // Build the expectation for the current cycle, then advance the model at the edge.
    task automatic cycle(string name, logic v, logic en, logic [4:0] rd, logic [1:0] sel,
                         logic [2:0] f3, logic [63:0] alu, logic [63:0] ld, logic [63:0] pc,
                         logic [4:0] r1, logic [4:0] r2, bit lit_en = 0, logic [63:0] lit_wb = 0);
        exp_t e;
        logic we;
        logic [63:0] wb;
        valid_W = v; wb_en_W = en; rd_W = rd; wb_sel_W = sel; funct3_W = f3;
        alu_out_W = alu; ld_data_W = ld; current_pc_W = pc;
        rs1_index = r1; rs2_index = r2;
        wb = model_wb(sel, f3, alu, ld, pc);
        we = rst && v && en && (sel != 2'b11) && (rd != 0);
        e.name = name;
        e.wb   = lit_en ? lit_wb : wb;
        e.r1   = (we && r1 == rd) ? wb : m_regs[r1];
        e.r2   = (we && r2 == rd) ? wb : m_regs[r2];
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (we) m_regs[rd] = wb;
            if (v) m_cnt = m_cnt + 64'd1;
        end
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_cnt = 64'd0;
    endtask

    localparam logic [63:0] LDW = 64'h8877665544332211;

    initial begin
        n_vec = 0;
        n_err = 0;
        model_clear();
        rst = 1'b0;
        valid_W = 0; wb_en_W = 0; rd_W = 0; wb_sel_W = 0; funct3_W = 0;
        alu_out_W = 0; ld_data_W = 0; current_pc_W = 0; rs1_index = 0; rs2_index = 0;
        @(posedge clk); #1;

        // Reset held with live writes: every index must read zero.
        for (int i = 0; i < 16; i++)
            cycle("reset_hold", 1, 1, 5'(i + 1), 2'b00, 3'b000, 64'hABCD_0000 + 64'(i), 0, 0,
                  5'(i), 5'(31 - i));

        rst = 1'b1;
        cycle("wr_x5", 1, 1, 5'd5, 2'b00, 3'b000, 64'h1234, 0, 0, 5'd0, 5'd1);
        cycle("rd_x5", 0, 0, 5'd0, 2'b00, 3'b000, 0, 0, 0, 5'd5, 5'd5);

        cycle("lb7",  1, 1, 5'd6, 2'b01, 3'b000, 64'h1007, LDW, 0, 5'd6, 5'd5, 1, 64'hFFFFFFFFFFFFFF88);
        cycle("lbu7", 1, 1, 5'd7, 2'b01, 3'b100, 64'h1007, LDW, 0, 5'd7, 5'd6, 1, 64'h88);
        cycle("lh6",  1, 1, 5'd8, 2'b01, 3'b001, 64'h1006, LDW, 0, 5'd8, 5'd7, 1, 64'hFFFFFFFFFFFF8877);
        cycle("lw4",  1, 1, 5'd9, 2'b01, 3'b010, 64'h1004, LDW, 0, 5'd9, 5'd8, 1, 64'hFFFFFFFF88776655);
        cycle("lwu4", 1, 1, 5'd11, 2'b01, 3'b110, 64'h1004, LDW, 0, 5'd11, 5'd9, 1, 64'h88776655);
        cycle("ld0",  1, 1, 5'd12, 2'b01, 3'b011, 64'h1000, LDW, 0, 5'd12, 5'd11, 1, LDW);
        cycle("lh7",  1, 1, 5'd13, 2'b01, 3'b001, 64'h1007, LDW, 0, 5'd13, 5'd12, 1, 64'h88);
        cycle("f3_111", 1, 1, 5'd14, 2'b01, 3'b111, 64'h1000, LDW, 0, 5'd14, 5'd13, 1, 64'h0);

        cycle("bypass", 1, 1, 5'd10, 2'b00, 3'b000, 64'hDEADBEEF, 0, 0, 5'd10, 5'd10, 1, 64'hDEADBEEF);
        cycle("stored", 0, 0, 5'd0, 2'b00, 3'b000, 0, 0, 0, 5'd10, 5'd10);

        cycle("x0_wr", 1, 1, 5'd0, 2'b00, 3'b000, 64'hFFFF, 0, 0, 5'd0, 5'd0, 1, 64'hFFFF);
        cycle("x0_rd", 1, 0, 5'd0, 2'b00, 3'b000, 0, 0, 0, 5'd0, 5'd10);
        cycle("sel11", 1, 1, 5'd15, 2'b11, 3'b000, 64'h5555, LDW, 64'h40, 5'd15, 5'd15, 1, 64'h0);
        cycle("bubble", 0, 1, 5'd16, 2'b00, 3'b000, 64'h7777, 0, 0, 5'd16, 5'd15);
        cycle("after", 0, 0, 5'd0, 2'b00, 3'b000, 0, 0, 0, 5'd16, 5'd15);
        cycle("jal_wrap", 1, 1, 5'd1, 2'b10, 3'b000, 0, 0, 64'hFFFFFFFFFFFFFFFC, 5'd1, 5'd2, 1, 64'h0);
        cycle("jal_link", 1, 1, 5'd2, 2'b10, 3'b000, 0, 0, 64'h8000, 5'd1, 5'd2, 1, 64'h8004);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            logic [4:0] r1;
            logic [4:0] r2;
            rd = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            cycle("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)) | 1'($urandom_range(0, 1)),
                  rd, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, r1, r2);
        end

        // Three writes, then reset between edges: outputs must clear without an edge.
        cycle("pre_rst1", 1, 1, 5'd3, 2'b00, 3'b000, 64'h31, 0, 0, 5'd3, 5'd4);
        cycle("pre_rst2", 1, 1, 5'd4, 2'b00, 3'b000, 64'h42, 0, 0, 5'd3, 5'd4);
        cycle("pre_rst3", 1, 1, 5'd17, 2'b00, 3'b000, 64'h53, 0, 0, 5'd3, 5'd17);
        rst = 1'b0;
        rs1_index = 5'd3; rs2_index = 5'd4; valid_W = 1'b0; wb_en_W = 1'b0;
        #1;
        model_clear();
        begin
            exp_t e;
            e.name = "async_rst"; e.r1 = 0; e.r2 = 0; e.cnt = 0;
            e.wb = model_wb(wb_sel_W, funct3_W, alu_out_W, ld_data_W, current_pc_W);
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        cycle("rst_edge", 1, 1, 5'd17, 2'b00, 3'b000, 64'h99, 0, 0, 5'd17, 5'd3);
        rst = 1'b1;
        cycle("post_rst", 1, 1, 5'd18, 2'b00, 3'b000, 64'hA5, 0, 0, 5'd17, 5'd4);
        cycle("post_rd", 0, 0, 5'd0, 2'b00, 3'b000, 0, 0, 0, 5'd18, 5'd3);

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
